// File: rtl/lmc_rx_deskew.sv
// Purpose : per-lane deskew FIFOs aligned on a per-lane marker, then unstripe of one beat per lane into a byte stream.
// Latency : one cycle from FIFO pop to LMCValid; two cycles from lane push to LMCValid at best.
// Backpr. : none toward the descramblers; a push to a full active lane raises deskewError and flushes all lanes.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   LANESNUMBER       active lane count (1,2,4,8,16; other values behave as 1)
//   laneData/K/Valid  per-lane beat, K flags and write strobe
//   laneMarker        per-lane flag: this beat is an alignment marker
//   LMCData/K/Valid   unstriped beat (byte k = b*N + l)
//   deskewLocked      all active lanes aligned
//   deskewError       one-cycle pulse on overflow or marker mismatch
//   lockSkew          occupancy spread at the last lock (only with LMC_SKEW_MEASURE_EN)
// Optional feature macro: LMC_SKEW_MEASURE_EN

module lmc_rx_deskew #(
  parameter int MAX_LANES    = 16,
  parameter int LANE_BYTES   = 4,
  parameter int DESKEW_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [4:0]                        LANESNUMBER,
  input  logic [MAX_LANES*LANE_BYTES*8-1:0] laneData,
  input  logic [MAX_LANES*LANE_BYTES-1:0]   laneDataK,
  input  logic [MAX_LANES-1:0]              laneValid,
  input  logic [MAX_LANES-1:0]              laneMarker,
  output logic [MAX_LANES*LANE_BYTES*8-1:0] LMCData,
  output logic [MAX_LANES*LANE_BYTES-1:0]   LMCDataK,
  output logic                              LMCValid,
  output logic                              deskewLocked,
  output logic                              deskewError
`ifdef LMC_SKEW_MEASURE_EN
  ,
  output logic [$clog2(DESKEW_DEPTH):0]     lockSkew
`endif
);

  localparam int LB8 = LANE_BYTES * 8;
  localparam int EW  = 1 + LANE_BYTES + LB8;  // {marker, K, data}
  localparam int PW  = $clog2(DESKEW_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic {ST_ALIGN, ST_LOCKED} state_t;

  state_t                      r_state, w_state_nxt;
  logic [EW-1:0]               r_mem [MAX_LANES][DESKEW_DEPTH];
  logic [PW-1:0]               r_wp  [MAX_LANES];
  logic [PW-1:0]               r_rp  [MAX_LANES];
  logic [CW-1:0]               r_cnt [MAX_LANES];
  logic [4:0]                  r_lanes_prev;
  logic                        r_valid, r_locked, r_err;
  logic [MAX_LANES*LB8-1:0]    r_data;
  logic [MAX_LANES*LANE_BYTES-1:0] r_k;

  logic [4:0]                  w_n;
  logic [MAX_LANES-1:0]        w_act, w_empty, w_full, w_push, w_pop;
  logic [EW-1:0]               w_head [MAX_LANES];
  logic                        w_all_ne, w_all_mk, w_any_mk;
  logic                        w_out, w_mism, w_ovf, w_chg, w_flush, w_err, w_lock_evt;
  logic [MAX_LANES*LB8-1:0]    w_udata;
  logic [MAX_LANES*LANE_BYTES-1:0] w_uk;

  // Lane count decode; anything that is not a supported power of two runs single-lane.
  always_comb begin
    w_n = 5'd1;
    case (LANESNUMBER)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: w_n = LANESNUMBER;
      default:                       w_n = 5'd1;
    endcase
    if (int'(w_n) > MAX_LANES) w_n = 5'd1;
  end

  always_comb begin
    w_all_ne = 1'b1;
    w_all_mk = 1'b1;
    w_any_mk = 1'b0;
    for (int l = 0; l < MAX_LANES; l++) begin
      w_act[l]   = (l < int'(w_n));
      w_empty[l] = (r_cnt[l] == '0);
      w_full[l]  = (r_cnt[l] == CW'(DESKEW_DEPTH));
      w_head[l]  = r_mem[l][r_rp[l]];
      if (w_act[l]) begin
        if (w_empty[l]) begin
          w_all_ne = 1'b0;
          w_all_mk = 1'b0;
        end else if (w_head[l][EW-1]) begin
          w_any_mk = 1'b1;
        end else begin
          w_all_mk = 1'b0;
        end
      end
    end
  end

  // Next state and pop control. Flush causes (lane-count change, overflow,
  // mismatch) override whatever the FSM decided.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_out       = 1'b0;
    w_mism      = 1'b0;
    w_lock_evt  = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_all_ne && w_all_mk) begin
          w_pop       = w_act;
          w_state_nxt = ST_LOCKED;
          w_lock_evt  = 1'b1;
        end else begin
          // Discard leading non-marker entries so every lane waits on a marker.
          for (int l = 0; l < MAX_LANES; l++)
            w_pop[l] = w_act[l] & ~w_empty[l] & ~w_head[l][EW-1];
        end
      end
      ST_LOCKED: begin
        if (w_all_ne) begin
          w_pop = w_act;
          if (!w_any_mk)      w_out  = 1'b1;
          else if (!w_all_mk) w_mism = 1'b1;
        end
      end
      default: w_state_nxt = ST_ALIGN;
    endcase
    w_push  = laneValid & w_act;
    // A full lane that pops this cycle has room for the push.
    w_ovf   = |(w_push & w_full & ~w_pop);
    w_chg   = (LANESNUMBER != r_lanes_prev);
    w_flush = w_chg | w_ovf | w_mism;
    w_err   = ~w_chg & (w_ovf | w_mism);
    if (w_flush) begin
      w_state_nxt = ST_ALIGN;
      w_out       = 1'b0;
      w_lock_evt  = 1'b0;
    end
  end

  // Unstripe: lane l byte b lands at output byte b*N + l; bytes beyond N*LANE_BYTES stay 0.
  always_comb begin
    w_udata = '0;
    w_uk    = '0;
    for (int l = 0; l < MAX_LANES; l++) begin
      for (int b = 0; b < LANE_BYTES; b++) begin
        if (l < int'(w_n)) begin
          w_udata[(b*int'(w_n)+l)*8 +: 8] = w_head[l][b*8 +: 8];
          w_uk[b*int'(w_n)+l]             = w_head[l][LB8+b];
        end
      end
    end
  end

  // Storage is not reset; occupancy counters define what is valid.
  always_ff @(posedge clk) begin
    for (int l = 0; l < MAX_LANES; l++) begin
      if (reset && !w_flush && w_push[l])
        r_mem[l][r_wp[l]] <= {laneMarker[l], laneDataK[l*LANE_BYTES +: LANE_BYTES], laneData[l*LB8 +: LB8]};
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < MAX_LANES; l++) begin
      if (!reset || w_flush) begin
        r_wp[l]  <= '0;
        r_rp[l]  <= '0;
        r_cnt[l] <= '0;
      end else begin
        if (w_push[l]) r_wp[l] <= r_wp[l] + PW'(1);
        if (w_pop[l])  r_rp[l] <= r_rp[l] + PW'(1);
        r_cnt[l] <= r_cnt[l] + CW'(w_push[l]) - CW'(w_pop[l]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_ALIGN;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_k          <= '0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_lanes_prev <= LANESNUMBER;
    end else begin
      r_state      <= w_state_nxt;
      r_valid      <= w_out;
      if (w_out) begin
        r_data <= w_udata;
        r_k    <= w_uk;
      end
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_err        <= w_err;
      r_lanes_prev <= LANESNUMBER;
    end
  end

  assign LMCData      = r_data;
  assign LMCDataK     = r_k;
  assign LMCValid     = r_valid;
  assign deskewLocked = r_locked;
  assign deskewError  = r_err;

`ifdef LMC_SKEW_MEASURE_EN
  logic [CW-1:0] r_skew, w_max, w_min;

  // Occupancy spread across active lanes just before the marker pop.
  always_comb begin
    w_max = '0;
    w_min = CW'(DESKEW_DEPTH);
    for (int l = 0; l < MAX_LANES; l++) begin
      if (w_act[l]) begin
        if (r_cnt[l] > w_max) w_max = r_cnt[l];
        if (r_cnt[l] < w_min) w_min = r_cnt[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)          r_skew <= '0;
    else if (w_lock_evt) r_skew <= w_max - w_min;
  end

  assign lockSkew = r_skew;
`endif

endmodule

// File: tb/tb_lmc_rx_deskew.sv
module tb_lmc_rx_deskew;

  localparam int ML = 16;
  localparam int LB = 4;
  localparam int DP = 8;
  localparam int DW = ML*LB*8;
  localparam int KW = ML*LB;

  logic          clk;
  logic          reset;
  logic [4:0]    lanes_num;
  logic [DW-1:0] lane_data;
  logic [KW-1:0] lane_k;
  logic [ML-1:0] lane_vld;
  logic [ML-1:0] lane_mk;
  logic [DW-1:0] lmc_dat;
  logic [KW-1:0] lmc_k;
  logic          lmc_vld;
  logic          locked;
  logic          err;
`ifdef LMC_SKEW_MEASURE_EN
  logic [$clog2(DP):0] skew;
`endif

  lmc_rx_deskew #(.MAX_LANES(ML), .LANE_BYTES(LB), .DESKEW_DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .LANESNUMBER(lanes_num),
    .laneData(lane_data), .laneDataK(lane_k), .laneValid(lane_vld), .laneMarker(lane_mk),
    .LMCData(lmc_dat), .LMCDataK(lmc_k), .LMCValid(lmc_vld),
    .deskewLocked(locked), .deskewError(err)
`ifdef LMC_SKEW_MEASURE_EN
    , .lockSkew(skew)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per lane plus a locked flag.
  typedef struct {
    bit            mk;
    bit [LB-1:0]   k;
    bit [LB*8-1:0] d;
  } ent_t;

  ent_t          mq [ML][$];
  bit            m_locked;
  int            m_prev;
  bit            e_vld, e_err, e_locked;
  bit [DW-1:0]   e_data;
  bit [KW-1:0]   e_k;
  int            e_skew;

  function automatic int decode(input int v);
    case (v)
      1, 2, 4, 8, 16: return v;
      default:        return 1;
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < ML; l++) mq[l].delete();
    m_locked = 0; m_prev = int'(lanes_num);
    e_vld = 0; e_err = 0; e_locked = 0; e_data = '0; e_k = '0; e_skew = 0;
  endtask

  task automatic model_step();
    int n, mx, mn, ln, bn;
    bit chg, all_ne, all_mk, any_mk, ovf, mism, do_out, lock_evt;
    bit pop [ML];
    ent_t e;
    n = decode(int'(lanes_num));
    chg = (int'(lanes_num) != m_prev);
    all_ne = 1; all_mk = 1; any_mk = 0; ovf = 0; mism = 0; do_out = 0; lock_evt = 0;
    for (int l = 0; l < ML; l++) pop[l] = 0;
    for (int l = 0; l < n; l++) begin
      if (mq[l].size() == 0) begin all_ne = 0; all_mk = 0; end
      else if (mq[l][0].mk) any_mk = 1;
      else all_mk = 0;
    end
    if (!m_locked) begin
      if (all_ne && all_mk) begin
        lock_evt = 1;
        for (int l = 0; l < n; l++) pop[l] = 1;
      end else begin
        for (int l = 0; l < n; l++) pop[l] = (mq[l].size() > 0) && !mq[l][0].mk;
      end
    end else if (all_ne) begin
      for (int l = 0; l < n; l++) pop[l] = 1;
      if (!any_mk)      do_out = 1;
      else if (!all_mk) mism = 1;
    end
    for (int l = 0; l < n; l++)
      if (lane_vld[l] && mq[l].size() == DP && !pop[l]) ovf = 1;
    e_vld = 0; e_err = 0;
    if (chg || ovf || mism) begin
      for (int l = 0; l < ML; l++) mq[l].delete();
      m_locked = 0;
      e_err = !chg;
    end else begin
      if (do_out) begin
        e_vld = 1;
        for (int k = 0; k < ML*LB; k++) begin
          if (k < n*LB) begin
            ln = k % n; bn = k / n;
            e_data[k*8 +: 8] = mq[ln][0].d[bn*8 +: 8];
            e_k[k]           = mq[ln][0].k[bn];
          end else begin
            e_data[k*8 +: 8] = 8'h00;
            e_k[k]           = 1'b0;
          end
        end
      end
      if (lock_evt) begin
        mx = 0; mn = DP;
        for (int l = 0; l < n; l++) begin
          if (mq[l].size() > mx) mx = mq[l].size();
          if (mq[l].size() < mn) mn = mq[l].size();
        end
        e_skew = mx - mn;
        m_locked = 1;
      end
      for (int l = 0; l < n; l++) begin
        if (pop[l]) void'(mq[l].pop_front());
        if (lane_vld[l]) begin
          e.mk = lane_mk[l]; e.k = lane_k[l*LB +: LB]; e.d = lane_data[l*LB*8 +: LB*8];
          mq[l].push_back(e);
        end
      end
    end
    e_locked = m_locked;
    m_prev = int'(lanes_num);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("valid",  DW'(lmc_vld), DW'(e_vld));
    check("locked", DW'(locked),  DW'(e_locked));
    check("error",  DW'(err),     DW'(e_err));
    if (e_vld) begin
      check("data",  lmc_dat,    e_data);
      check("datak", DW'(lmc_k), DW'(e_k));
    end
`ifdef LMC_SKEW_MEASURE_EN
    check("skew", DW'(skew), DW'(e_skew));
`endif
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < ML; i++) lane_data[i*LB*8 +: LB*8] = $urandom;
    lane_k = {$urandom, $urandom};
  endtask

  // Sends nbeats per active lane; lane l's beat j goes out at stream cycle j+dly[l].
  // Beats with j%5==0 are markers; (mis_lane, mis_beat) gets a stray marker.
  task automatic run_stream(input int nraw, input int dly [ML], input int nbeats,
                            input int mis_lane, input int mis_beat, input int stall_pct);
    int n, maxd, c, j;
    n = decode(nraw);
    maxd = 0;
    lanes_num = 5'(nraw);
    lane_vld = '0; lane_mk = '0;
    step();
    for (int l = 0; l < n; l++) if (dly[l] > maxd) maxd = dly[l];
    c = 0;
    for (int cyc = 0; c < nbeats + maxd && cyc < 1000; cyc++) begin
      lane_vld = '0; lane_mk = '0;
      randomize_lanes();
      if (int'($urandom_range(99)) >= stall_pct) begin
        for (int l = 0; l < ML; l++) begin
          if (l >= n) begin
            lane_vld[l] = 1'($urandom_range(1));
            lane_mk[l]  = 1'($urandom_range(1));
          end else begin
            j = c - dly[l];
            if (j >= 0 && j < nbeats) begin
              lane_vld[l] = 1'b1;
              lane_mk[l]  = (j % 5 == 0) || (l == mis_lane && j == mis_beat);
            end
          end
        end
        c++;
      end
      step();
    end
    lane_vld = '0; lane_mk = '0;
    repeat (4) step();
  endtask

  int          dz [ML];
  int          dd [ML];
  logic [7:0]  lane1_b0;
  int          nsel [5] = '{1, 2, 4, 8, 16};

  initial begin
    for (int l = 0; l < ML; l++) dz[l] = 0;
    reset = 1'b0; lanes_num = 5'd4; lane_vld = '0; lane_mk = '0; lane_data = '0; lane_k = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid",  DW'(lmc_vld), DW'(0));
    check("rst_locked", DW'(locked),  DW'(0));
    check("rst_error",  DW'(err),     DW'(0));
    check("rst_data",   lmc_dat,      DW'(0));
`ifdef LMC_SKEW_MEASURE_EN
    check("rst_skew",   DW'(skew),    DW'(0));
`endif
    model_reset();
    reset = 1'b1;

    // Aligned markers on lanes 0..3, then one data beat.
    randomize_lanes();
    lane_vld = 16'h000F; lane_mk = 16'h000F;
    step();
    randomize_lanes();
    lane_mk = '0;
    lane1_b0 = lane_data[1*LB*8 +: 8];
    step();
    check("lock_2cyc", DW'(locked), DW'(1));
    lane_vld = '0;
    step();
    check("first_vld", DW'(lmc_vld), DW'(1));
    check("byte1_l1b0", DW'(lmc_dat[15:8]), DW'(lane1_b0));
    repeat (2) step();

    // Lane 2 three beats late.
    dd = dz; dd[2] = 3;
    run_stream(4, dd, 16, -1, -1, 0);

    // Lane 0 eight beats late: overflow, then aligned relock.
    dd = dz; dd[0] = 8;
    run_stream(4, dd, 16, -1, -1, 0);
    run_stream(4, dz, 12, -1, -1, 0);

    // Stray marker on lane 1 while locked.
    run_stream(4, dz, 16, 1, 7, 0);

    // Full width with skew and stalls, then single lane.
    for (int l = 0; l < ML; l++) dd[l] = int'($urandom_range(5));
    run_stream(16, dd, 20, -1, -1, 20);
    run_stream(1, dz, 11, -1, -1, 0);

    // Lane count change while locked, and an unsupported value.
    run_stream(8, dz, 12, -1, -1, 0);
    run_stream(2, dz, 12, -1, -1, 0);
    run_stream(3, dz, 11, -1, -1, 10);

    // Randomised mixes.
    for (int it = 0; it < 8; it++) begin
      for (int l = 0; l < ML; l++) dd[l] = int'($urandom_range(DP-1));
      run_stream(nsel[$urandom_range(4)], dd, int'($urandom_range(10, 25)),
                 int'($urandom_range(15)), int'($urandom_range(1, 30)), 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
